// File: rtl/stdp_synapse_pkg.sv
// Shared widths, types and the weight clamp helper for the STDP synapse.
// The sum width leaves headroom so weight + ltp - ltd can never wrap before clamping.
package stdp_synapse_pkg;

  localparam int WEIGHT_W    = 8;
  localparam int TRACE_W     = 8;
  localparam int SUM_W       = 10;
  localparam int DECAY_FLOOR = 4;

  typedef logic [WEIGHT_W-1:0]     weight_t;
  typedef logic [TRACE_W-1:0]      trace_t;
  typedef logic signed [SUM_W-1:0] sum_t;

  function automatic weight_t clamp_w(input sum_t sum, input weight_t lo, input weight_t hi);
    sum_t lo_s;
    sum_t hi_s;
    lo_s = sum_t'({{(SUM_W-WEIGHT_W){1'b0}}, lo});
    hi_s = sum_t'({{(SUM_W-WEIGHT_W){1'b0}}, hi});
    if (sum < lo_s) begin
      clamp_w = lo;
    end else if (sum > hi_s) begin
      clamp_w = hi;
    end else begin
      clamp_w = sum[WEIGHT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/stdp_synapse_if.sv
// Spike, learning-control and observation signals of one plastic synapse.
// The master side drives spikes and weight loads; the synapse side returns current, weight and traces.
interface stdp_synapse_if;
  import stdp_synapse_pkg::*;

  logic    pre_spike;
  logic    post_spike;
  logic    learn_en;
  logic    w_load;
  weight_t w_load_val;
  weight_t current;
  weight_t weight;
  trace_t  pre_trace;
  trace_t  post_trace;

  modport master (
    output pre_spike, post_spike, learn_en, w_load, w_load_val,
    input  current, weight, pre_trace, post_trace
  );

  modport slave (
    input  pre_spike, post_spike, learn_en, w_load, w_load_val,
    output current, weight, pre_trace, post_trace
  );

endinterface

// File: rtl/stdp_synapse_trace.sv
// Eligibility trace: jumps to TRACE_MAX on a spike, otherwise decays by x0.75 (truncating).
// Values below DECAY_FLOOR are forced to zero, otherwise the shift-based decay would stall at 3.
module stdp_synapse_trace
  import stdp_synapse_pkg::*;
#(
  parameter trace_t TRACE_MAX = 8'd255
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   spike_i,
  output trace_t trace_o
);

  trace_t trace_q;
  trace_t trace_d;

  always_comb begin
    trace_d = trace_q;
    if (spike_i) begin
      trace_d = TRACE_MAX;
    end else if (trace_q < trace_t'(DECAY_FLOOR)) begin
      trace_d = '0;
    end else begin
      trace_d = trace_q - (trace_q >> 2);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trace_q <= '0;
    end else begin
      trace_q <= trace_d;
    end
  end

  assign trace_o = trace_q;

endmodule

// File: rtl/stdp_synapse.sv
// Plastic synapse: emits a one-cycle current pulse equal to the weight per pre spike and
// learns the weight by pair-based STDP (LTP on post spike, LTD on pre spike) from pre-edge traces.
module stdp_synapse
  import stdp_synapse_pkg::*;
#(
  parameter weight_t W_INIT    = 8'd64,
  parameter weight_t W_MAX     = 8'd255,
  parameter weight_t W_MIN     = 8'd0,
  parameter trace_t  TRACE_MAX = 8'd255,
  parameter int      LTP_SHIFT = 2,
  parameter int      LTD_SHIFT = 3
) (
  input logic           clk,
  input logic           rst_n,
  stdp_synapse_if.slave bus
);

  trace_t  pre_trace;
  trace_t  post_trace;
  trace_t  ltp;
  trace_t  ltd;
  sum_t    sum;
  weight_t weight_q;
  weight_t weight_d;
  weight_t current_q;
  weight_t current_d;

  stdp_synapse_trace #(.TRACE_MAX(TRACE_MAX)) u_pre_trace (
    .clk     (clk),
    .rst_n   (rst_n),
    .spike_i (bus.pre_spike),
    .trace_o (pre_trace)
  );

  stdp_synapse_trace #(.TRACE_MAX(TRACE_MAX)) u_post_trace (
    .clk     (clk),
    .rst_n   (rst_n),
    .spike_i (bus.post_spike),
    .trace_o (post_trace)
  );

  // Both terms read the registered traces, so a spike never sees its own trace jump.
  always_comb begin
    ltp = bus.post_spike ? (pre_trace >> LTP_SHIFT) : '0;
    ltd = bus.pre_spike  ? (post_trace >> LTD_SHIFT) : '0;
    sum = sum_t'({{(SUM_W-WEIGHT_W){1'b0}}, weight_q})
        + sum_t'({{(SUM_W-TRACE_W){1'b0}}, ltp})
        - sum_t'({{(SUM_W-TRACE_W){1'b0}}, ltd});
  end

  always_comb begin
    weight_d  = weight_q;
    current_d = bus.pre_spike ? weight_q : '0;
    if (bus.w_load) begin
      weight_d = bus.w_load_val;
    end else if (bus.learn_en) begin
      weight_d = clamp_w(sum, W_MIN, W_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      weight_q  <= W_INIT;
      current_q <= '0;
    end else begin
      weight_q  <= weight_d;
      current_q <= current_d;
    end
  end

  assign bus.current    = current_q;
  assign bus.weight     = weight_q;
  assign bus.pre_trace  = pre_trace;
  assign bus.post_trace = post_trace;

endmodule

// File: tb/tb_stdp_synapse.sv
// Bench for stdp_synapse: directed vector table, a retrigger sequence, then random traffic
// compared against an arithmetic reference model of weight, current and both traces.
module tb_stdp_synapse;

  logic clk;
  logic rst_n;

  stdp_synapse_if bus ();

  stdp_synapse dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       rst_n;
    logic       pre;
    logic       post;
    logic       learn;
    logic       wload;
    logic [7:0] wval;
    logic [7:0] e_w;
    logic [7:0] e_cur;
    logic [7:0] e_pt;
    logic [7:0] e_qt;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void v(input logic r, input logic p, input logic q, input logic l,
                            input logic wl, input int wv, input int ew, input int ec,
                            input int ept, input int eqt);
    vec_t t;
    t.rst_n = r;  t.pre = p;  t.post = q;  t.learn = l;  t.wload = wl;
    t.wval  = 8'(wv);  t.e_w = 8'(ew);  t.e_cur = 8'(ec);
    t.e_pt  = 8'(ept); t.e_qt = 8'(eqt);
    vecs.push_back(t);
  endfunction

  task automatic apply(input logic r, input logic p, input logic q, input logic l,
                       input logic wl, input logic [7:0] wv);
    @(negedge clk);
    rst_n          = r;
    bus.pre_spike  = p;
    bus.post_spike = q;
    bus.learn_en   = l;
    bus.w_load     = wl;
    bus.w_load_val = wv;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input int ew, input int ec, input int ept, input int eqt);
    check("weight",     idx, bus.weight,     8'(ew));
    check("current",    idx, bus.current,    8'(ec));
    check("pre_trace",  idx, bus.pre_trace,  8'(ept));
    check("post_trace", idx, bus.post_trace, 8'(eqt));
  endtask

  initial begin
    int dec[19];
    int m_w, m_c, m_pt, m_qt, s, nc, wv;
    logic r, p, q, l, wl;

    rst_n = 1'b0;
    bus.pre_spike = 1'b0; bus.post_spike = 1'b0; bus.learn_en = 1'b0;
    bus.w_load = 1'b0; bus.w_load_val = 8'd0;

    // reset ignores everything else, including a load and spikes
    v(0,1,1,1,1,200, 64,0,0,0);
    v(0,1,0,0,0,0,   64,0,0,0);
    // current pulse and trace decay to zero with learning off
    v(1,1,0,0,0,0,   64,64,255,0);
    dec = '{192,144,108,81,61,46,35,27,21,16,12,9,7,6,5,4,3,0,0};
    for (int i = 0; i < 19; i++) v(1,0,0,0,0,0, 64,0,dec[i],0);
    // LTP: pre then post
    v(1,1,0,1,0,0,   64,64,255,0);
    v(1,0,1,1,0,0,   127,0,192,255);
    // LTD: post then pre, current uses the pre-update weight
    v(0,0,0,0,0,0,   64,0,0,0);
    v(1,0,1,1,0,0,   64,0,0,255);
    v(1,1,0,1,0,0,   33,64,255,192);
    // upper clamp
    v(0,0,0,0,0,0,   64,0,0,0);
    v(1,0,0,1,1,250, 250,0,0,0);
    v(1,1,0,1,0,0,   250,250,255,0);
    v(1,0,1,1,0,0,   255,0,192,255);
    // lower clamp
    v(0,0,0,0,0,0,   64,0,0,0);
    v(1,0,0,1,1,10,  10,0,0,0);
    v(1,0,1,1,0,0,   10,0,0,255);
    v(1,1,0,1,0,0,   0,10,255,192);
    // load suppresses learning; then simultaneous pre+post from full traces
    v(1,1,1,1,1,100, 100,0,255,255);
    v(1,1,1,1,0,0,   132,100,255,255);
    // load wins over LTP
    v(1,0,1,1,1,7,   7,0,192,255);
    // frozen weight, traces still run
    v(1,1,1,0,0,0,   7,7,255,255);
    v(1,0,1,0,0,0,   7,0,192,255);
    // reset mid-operation
    v(0,1,0,1,0,0,   64,0,0,0);
    v(1,1,0,0,0,0,   64,64,255,0);

    foreach (vecs[i]) begin
      apply(vecs[i].rst_n, vecs[i].pre, vecs[i].post, vecs[i].learn, vecs[i].wload, vecs[i].wval);
      check_all(i, vecs[i].e_w, vecs[i].e_cur, vecs[i].e_pt, vecs[i].e_qt);
    end

    // retrigger overwrites a partly decayed trace
    apply(1,0,0,0,0,0); check_all(1000, 64,0,192,0);
    apply(1,0,0,0,0,0); check_all(1001, 64,0,144,0);
    apply(1,1,0,0,0,0); check_all(1002, 64,64,255,0);
    apply(1,1,0,0,0,0); check_all(1003, 64,64,255,0);

    // random traffic against the reference model
    m_w = 64; m_c = 0; m_pt = 0; m_qt = 0;
    for (int n = 0; n < 1500; n++) begin
      r  = (n == 0) ? 1'b0 : ($urandom_range(0, 63) != 0);
      p  = ($urandom_range(0, 3) == 0);
      q  = ($urandom_range(0, 3) == 0);
      l  = ($urandom_range(0, 3) != 0);
      wl = ($urandom_range(0, 19) == 0);
      wv = $urandom_range(0, 255);
      apply(r, p, q, l, wl, 8'(wv));
      if (!r) begin
        m_w = 64; m_c = 0; m_pt = 0; m_qt = 0;
      end else begin
        nc = p ? m_w : 0;
        if (wl) begin
          m_w = wv;
        end else if (l) begin
          s = m_w + (q ? m_pt / 4 : 0) - (p ? m_qt / 8 : 0);
          m_w = (s < 0) ? 0 : ((s > 255) ? 255 : s);
        end
        m_pt = p ? 255 : ((m_pt < 4) ? 0 : m_pt - m_pt / 4);
        m_qt = q ? 255 : ((m_qt < 4) ? 0 : m_qt - m_qt / 4);
        m_c  = nc;
      end
      check_all(2000 + n, m_w, m_c, m_pt, m_qt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
